ram_router: RTL

Parametrised, registered successor to the combinational RAM steering logic. It sits between the memory stage and N_CH RAM/peripheral channel controllers. It decodes the access address to one channel, or to the memory-mapped status word, and drives a one-hot work request to that channel. It holds the request until the channel reports completion, then returns the channel's data with a `work_done` handshake. An optional watchdog aborts hung channel accesses.

---
 rtl/ram_router.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ram_router.sv
// Registered RAM/peripheral request router: decodes an access to one of N_CH channels or the
// internal status word. Optional watchdog enabled by defining RAM_ROUTER_TIMEOUT_EN.
module ram_router #(
  parameter int            ADDR_W      = 16,
  parameter int            DATA_W      = 16,
  parameter int            SEL_W       = 1,
  parameter logic [15:0]   STATUS_ADDR = 16'hBF01,
  parameter int            TIMEOUT_CYC = 255,
  localparam int           N_CH        = 2 ** SEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_rd,
  input  logic                   mem_wr,
  input  logic                   init_mem_wr,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   uart_received_data,
  input  logic [N_CH-1:0]        ch_work_done,
  input  logic [N_CH*DATA_W-1:0] ch_feedback,
  output logic [N_CH-1:0]        ch_need_to_work,
  output logic                   work_done,
  output logic [DATA_W-1:0]      feedback,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N_CH-1:0] ONE_HOT_0 = {{(N_CH-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [N_CH-1:0]     r_need;
  logic [N_CH-1:0]     w_need_nxt;
  logic [DATA_W-1:0]   r_feedback;
  logic [DATA_W-1:0]   w_feedback_nxt;
  logic                r_work_done;
  logic                r_busy;

  logic                w_req;
  logic                w_is_status;
  logic [SEL_W-1:0]    w_addr_sel;
  logic                w_sel_done;
  logic [DATA_W-1:0]   w_sel_data;
  logic [DATA_W-1:0]   w_status_word;

  assign w_req         = mem_rd | mem_wr | init_mem_wr;
  assign w_is_status   = (addr == ADDR_W'(STATUS_ADDR));
  assign w_addr_sel    = addr[ADDR_W-1 -: SEL_W];
  assign w_sel_done    = ch_work_done[r_sel];
  assign w_sel_data    = ch_feedback[r_sel*DATA_W +: DATA_W];
  assign w_status_word = {{(DATA_W-2){1'b1}}, uart_received_data, 1'b1};

`ifdef RAM_ROUTER_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_err;
  logic             w_err_nxt;
`endif

  // Next-state and next-register-value decode for the access FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_need_nxt     = r_need;
    w_feedback_nxt = r_feedback;
`ifdef RAM_ROUTER_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_sel_nxt = w_addr_sel;
          if (w_is_status) begin
            w_feedback_nxt = w_status_word;
            w_state_nxt    = S_DONE;
          end else begin
            w_need_nxt  = ONE_HOT_0 << w_addr_sel;
            w_state_nxt = S_BUSY;
`ifdef RAM_ROUTER_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        // Completion is checked first so it wins over a simultaneous watchdog expiry
        if (w_sel_done) begin
          w_feedback_nxt = w_sel_data;
          w_need_nxt     = '0;
          w_state_nxt    = S_DONE;
`ifdef RAM_ROUTER_TIMEOUT_EN
        end else if (r_cnt == CNT_TOP) begin
          w_feedback_nxt = '1;
          w_need_nxt     = '0;
          w_err_nxt      = 1'b1;
          w_state_nxt    = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
`else
        end else begin
          w_state_nxt = S_BUSY;
`endif
        end
      end
      S_DONE: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_need_nxt  = '0;
      end
    endcase
  end

  // State and registered outputs; handshake flags follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_need      <= '0;
      r_feedback  <= '0;
      r_work_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_need      <= w_need_nxt;
      r_feedback  <= w_feedback_nxt;
      r_work_done <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef RAM_ROUTER_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign ch_need_to_work = r_need;
  assign work_done       = r_work_done;
  assign feedback        = r_feedback;
  assign busy            = r_busy;

endmodule
